bram_stream_reader: RTL and testbench

- Reads a block of 32-bit ECG samples from port B of the team's dual-port 4096x32 sample BRAM.
- Sources the samples onto a valid/ready stream for the downstream filter/feature pipeline.
- Acts as the consumer for the BRAM that the acquisition side writes through port A.
- Each transfer is programmed with a base address and a word count, handles the BRAM's 1-cycle read latency, and supports full-rate streaming under arbitrary backpressure.

---
 rtl/bram_stream_reader.sv | 183 ++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a programmed block of words out of port B of the sample BRAM onto a
// valid/ready interface, absorbing the 1-cycle read latency with a 2-entry buffer.
module bram_stream_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [LEN_W-1:0]  issue_rem_r;
  logic [LEN_W-1:0]  beat_rem_r;
  logic              inflight_r;
  logic [1:0]        count_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] second_r;
  logic              busy_r;
  logic              done_r;

  logic              pop_s;
  logic              last_pop_s;
  logic              issue_s;
  logic              load_s;
  logic              done_s;
  logic [2:0]        occ_s;

  assign tvalid     = (count_r != 2'd0);
  assign tdata      = head_r;
  assign tlast      = tvalid && (beat_rem_r == LEN_W'(1));
  assign pop_s      = tvalid && tready;
  assign last_pop_s = pop_s && (beat_rem_r == LEN_W'(1));
  // Words already committed to the buffer: stored plus the one on bram_dout, less this cycle's pop.
  assign occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  assign busy      = busy_r;
  assign done      = done_r;
  assign bram_addr = ptr_r;
  assign bram_en   = issue_s;
  assign bram_we   = 1'b0;
  assign bram_din  = {DATA_W{1'b0}};

  // Next-state, read-issue and completion decode.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    load_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (length != LEN_W'(0)) begin
            state_s = S_RUN;
            load_s  = 1'b1;
          end else begin
            done_s  = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if ((issue_rem_r != LEN_W'(0)) && (occ_s < 3'd2)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (last_pop_s) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else if (issue_rem_r == LEN_W'(0)) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (last_pop_s) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Control state, read pointer and word counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      inflight_r  <= 1'b0;
      ptr_r       <= {ADDR_W{1'b0}};
      issue_rem_r <= {LEN_W{1'b0}};
      beat_rem_r  <= {LEN_W{1'b0}};
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != S_IDLE);
      done_r     <= done_s;
      inflight_r <= issue_s;
      if (load_s) begin
        ptr_r       <= base_addr;
        issue_rem_r <= length;
      end else if (issue_s) begin
        ptr_r       <= ptr_r + ADDR_W'(1);
        issue_rem_r <= issue_rem_r - LEN_W'(1);
      end else begin
        ptr_r       <= ptr_r;
        issue_rem_r <= issue_rem_r;
      end
      if (load_s) begin
        beat_rem_r <= length;
      end else if (pop_s) begin
        beat_rem_r <= beat_rem_r - LEN_W'(1);
      end else begin
        beat_rem_r <= beat_rem_r;
      end
    end
  end

  // Two-entry output buffer; the head register drives the stream.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r  <= 2'd0;
      head_r   <= {DATA_W{1'b0}};
      second_r <= {DATA_W{1'b0}};
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= bram_dout;
          end else begin
            second_r <= bram_dout;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= second_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= bram_dout;
          end else begin
            head_r   <= second_r;
            second_r <= bram_dout;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 4096x32 BRAM on port B.
module tb_bram_stream_reader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] bram_addr;
  logic        bram_en;
  logic        bram_we;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  logic [31:0] mem [0:4095];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  bit busy_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_last = 1'b0;
  logic [31:0] got_d [$];
  logic        got_l [$];
  int          got_c [$];
  logic [11:0] addr_q [$];

  bram_stream_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B read model with 1-cycle latency.
  always @(posedge clk) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle observation at the falling edge: invariants plus handshake capture.
  task automatic observe();
    logic pop;
    pop = tvalid && tready;
    chk("bram_we", 64'(bram_we), 64'(0));
    chk("bram_din", 64'(bram_din), 64'(0));
    if (rstn && bram_en) chk("occupancy_lt_2", 64'((issued - beats - (pop ? 1 : 0)) < 2), 64'(1));
    if (prev_stall) begin
      chk("hold_tvalid", 64'(tvalid), 64'(1));
      chk("hold_tdata", 64'(tdata), 64'(prev_data));
      chk("hold_tlast", 64'(tlast), 64'(prev_last));
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("done_with_tvalid", 64'(tvalid), 64'(0));
    end
    if (busy) busy_seen = 1'b1;
    if (pop) begin
      got_d.push_back(tdata);
      got_l.push_back(tlast);
      got_c.push_back(cyc);
    end
    if (rstn && bram_en) addr_q.push_back(bram_addr);
    if (!rstn) begin
      issued = 0;
      beats = 0;
      prev_stall = 1'b0;
    end else begin
      issued += bram_en ? 1 : 0;
      beats += pop ? 1 : 0;
      prev_stall = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c < 16) return (c % 4 == 0) || (c % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic clear_logs();
    got_d.delete();
    got_l.delete();
    got_c.delete();
    addr_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_seen = 1'b0;
  endtask

  // One transfer: Start in cycle 0, run until Done or budget, then two idle cycles.
  task automatic run_xfer(input logic [11:0] b, input logic [12:0] n, input int mode,
                          input int restart_at, input int budget);
    clear_logs();
    start = 1'b1;
    base_addr = b;
    length = n;
    for (cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      tready = rdy(mode, cyc);
      if (cyc == restart_at) begin
        start = 1'b1;
        base_addr = 12'h100;
        length = 13'd5;
      end
      @(negedge clk);
      observe();
      next_cycle();
      start = 1'b0;
    end
    tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      observe();
      next_cycle();
      cyc++;
    end
    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("beat_count", 64'(got_d.size()), 64'(n));
    for (int i = 0; i < got_d.size() && i < int'(n); i++) begin
      chk("data", 64'(got_d[i]), 64'(32'hA000_0000 + 32'((int'(b) + i) % 4096)));
      chk("tlast", 64'(got_l[i]), 64'(i == int'(n) - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bram_dout = 32'h0;
    rstn = 1'b0;
    start = 1'b0;
    base_addr = 12'h0;
    length = 13'd0;
    tready = 1'b0;

    // Reset state.
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bram_en", 64'(bram_en), 64'(0));
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_bram_addr", 64'(bram_addr), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    next_cycle();
    rstn = 1'b1;
    tready = 1'b1;
    next_cycle();

    // Base 0x010, length 4, cycle-exact latency.
    clear_logs();
    start = 1'b1;
    base_addr = 12'h010;
    length = 13'd4;
    for (int k = 0; k < 9; k++) begin
      cyc = k;
      @(negedge clk);
      observe();
      chk("t1_bram_en", 64'(bram_en), 64'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk("t1_bram_addr", 64'(bram_addr), 64'(12'h010 + 12'(k - 1)));
      chk("t1_tvalid", 64'(tvalid), 64'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("t1_tdata", 64'(tdata), 64'(32'hA000_0010 + 32'(k - 3)));
      chk("t1_tlast", 64'(tlast), 64'(k == 6));
      chk("t1_done", 64'(done), 64'(k == 7));
      chk("t1_busy", 64'(busy), 64'(k >= 1 && k <= 6));
      next_cycle();
      start = 1'b0;
    end
    chk("t1_done_count", 64'(done_cnt), 64'(1));

    // Address wrap at the top of the BRAM.
    run_xfer(12'hFFE, 13'd4, 0, -1, 30);
    chk("wrap_issue_count", 64'(addr_q.size()), 64'(4));
    if (addr_q.size() == 4) begin
      chk("wrap_addr0", 64'(addr_q[0]), 64'(12'hFFE));
      chk("wrap_addr1", 64'(addr_q[1]), 64'(12'hFFF));
      chk("wrap_addr2", 64'(addr_q[2]), 64'(12'h000));
      chk("wrap_addr3", 64'(addr_q[3]), 64'(12'h001));
    end

    // Backpressure: fixed 1,0,0,1 pattern then random.
    run_xfer(12'h200, 13'd8, 1, -1, 300);
    run_xfer(12'h7F0, 13'd20, 1, -1, 400);

    // Zero length: Done one cycle after Start, no beats, never busy.
    run_xfer(12'h050, 13'd0, 0, -1, 10);
    chk("len0_done_cycle", 64'(done_cyc), 64'(1));
    chk("len0_busy", 64'(busy_seen), 64'(0));

    // Second Start while busy is ignored.
    run_xfer(12'h030, 13'd6, 0, 3, 40);

    // Reset after the third beat.
    clear_logs();
    start = 1'b1;
    base_addr = 12'h040;
    length = 13'd8;
    tready = 1'b1;
    for (cyc = 0; cyc < 7; cyc++) begin
      if (cyc == 6) begin
        tready = 1'b0;
        rstn = 1'b0;
      end
      @(negedge clk);
      observe();
      next_cycle();
      start = 1'b0;
    end
    rstn = 1'b1;
    tready = 1'b1;
    chk("rstmid_beats", 64'(got_d.size()), 64'(3));
    if (got_d.size() == 3) chk("rstmid_beat2", 64'(got_d[2]), 64'(32'hA000_0042));
    @(negedge clk);
    observe();
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_done", 64'(done), 64'(0));
    chk("rstmid_bram_en", 64'(bram_en), 64'(0));
    chk("rstmid_tvalid", 64'(tvalid), 64'(0));
    chk("rstmid_tlast", 64'(tlast), 64'(0));
    chk("rstmid_bram_addr", 64'(bram_addr), 64'(0));
    chk("rstmid_tdata", 64'(tdata), 64'(0));
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      cyc++;
      @(negedge clk);
      observe();
      chk("rstmid_no_tvalid", 64'(tvalid), 64'(0));
    end
    chk("rstmid_no_done", 64'(done_cnt), 64'(0));
    next_cycle();
    run_xfer(12'h020, 13'd2, 0, -1, 20);

    // Full-size transfer at full rate.
    run_xfer(12'h000, 13'd4096, 0, -1, 4200);
    if (got_c.size() == 4096) begin
      chk("full_first_beat", 64'(got_c[0]), 64'(3));
      chk("full_last_beat", 64'(got_c[4095]), 64'(4098));
    end
    chk("full_done_cycle", 64'(done_cyc), 64'(4099));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
